// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between a CPU and a word-addressed data memory.
// The memory writes on the clock edge and reads combinationally.
//   - Byte, halfword and word requests become word accesses.
//   - Sub-word stores use read-modify-write.
//   - Loads are lane-extracted and then sign- or zero-extended.
//   - Misaligned or illegal requests complete with err and never touch memory.
//
// Ports
//   clk_i, reset_i      clock; asynchronous active-high reset
//   start_i             request strobe, sampled only in IDLE
//   op_write_i          1 = store, 0 = load
//   size_i              00 byte, 01 half, 10 word, 11 illegal
//   sign_ext_i          loads only: 1 = sign-extend
//   cpu_addr_i          byte address
//   cpu_wdata_i         store data, right-justified
//   busy_o              high whenever the FSM is not in IDLE
//   done_o, err_o       one-cycle completion pulse; err_o is valid with done_o
//   rdata_o             load result, held until the next completed load
//   mem_addr_o          word-aligned memory address
//   mem_wd_o            memory write data
//   mem_write_o         memory write enable
//   mem_rd_i            memory read data
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | memory word captured (load result or RMW merge source)
// WRITE | single-cycle memory write
// DONE  | done_o pulse, err_o reports the latched result
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              op_write_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t              state_q, state_d;
  logic                op_write_q;
  logic [1:0]          size_q;
  logic                sign_ext_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                req_err;
  logic                accept;
  logic [DATA_W-1:0]   rd_shift;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   merged;

  assign req_err = (size_i == SZ_ILL) ||
                   ((size_i == SZ_HALF) && cpu_addr_i[0]) ||
                   ((size_i == SZ_WORD) && (cpu_addr_i[1:0] != 2'b00));

  assign accept = (state_q == IDLE) && start_i;

  // Lane extraction for loads; little-endian, lane taken from the latched address.
  assign rd_shift = mem_rd_i >> {addr_q[1:0], 3'b000};
  assign byte_sel = rd_shift[7:0];
  assign half_sel = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    load_val = mem_rd_i;
    case (size_q)
      SZ_BYTE: load_val = {{24{sign_ext_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{sign_ext_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rd_i;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane(s) of the captured word.
  always_comb begin
    merged = merge_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (req_err)                  state_d = DONE;
          else if (!op_write_i)         state_d = READ;
          else if (size_i == SZ_WORD)   state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ: begin
        if (op_write_q) begin
          merge_d = mem_rd_i;
          state_d = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      size_q     <= SZ_BYTE;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      merge_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      if (accept) begin
        op_write_q <= op_write_i;
        size_q     <= size_i;
        sign_ext_q <= sign_ext_i;
        addr_q     <= cpu_addr_i;
        wdata_q    <= cpu_wdata_i;
        err_q      <= req_err;
      end
    end
  end

  // Address and write data are gated so that memory sees zeros whenever no access is in flight.
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;
  assign rdata_o     = rdata_q;
  assign mem_write_o = (state_q == WRITE);
  assign mem_addr_o  = ((state_q == READ) || (state_q == WRITE)) ?
                       {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wd_o    = (state_q == WRITE) ? merged : '0;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side load/store sequencer for the multi-cycle processor; drives the word-addressed data memory (addr/WD/MemWrite/RD, writes on clk edge, combinational read).
- Converts CPU byte/halfword/word load and store requests into word accesses.
- Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
- Flags misaligned or illegal requests without touching memory.

Parameters:
- ADDR_W, 32, byte-address width of cpu_addr and mem_addr.
- DATA_W, 32, memory word width; fixed at 32 (4 byte lanes).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- op_write  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-justified
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned or illegal size
- rdata  output  32  load result; held until next completed load
- mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}
- mem_wd  output  32  write data to memory
- mem_write  output  1  memory write enable (MemWrite)
- mem_rd  input  32  memory read data (RD), combinational from mem_addr

Behaviour:
- Request latching: start in IDLE latches op_write, size, sign_ext, cpu_addr, cpu_wdata into internal registers. start in any other state is ignored, with no queuing.
- Moore FSM states: IDLE, READ, WRITE, DONE.
- IDLE transitions:
  - Error → DONE (err=1). Error is size==11, size==01 with addr[0]=1, or size==10 with addr[1:0]!=0.
  - Load → READ.
  - Word store → WRITE.
  - Byte/half store → READ.
- READ: mem_addr driven, mem_rd captured at the edge.
  - Load → DONE, with the extracted/extended value written to rdata.
  - Sub-word store → WRITE, with the captured word held in a merge register.
- WRITE: mem_write=1 for exactly one cycle.
  - mem_wd = cpu_wdata for a word store.
  - For a sub-word store, mem_wd = captured word with the selected lane(s) replaced by cpu_wdata[7:0] or [15:0].
  - WRITE → DONE.
- DONE: done=1 for one cycle, err per latched result, then → IDLE.
- Latency from the start-accepting edge to done:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Lanes are little-endian: byte k = bits [8k+7:8k]. Halfword at addr[1]=0 uses [15:0]; at addr[1]=1 uses [31:16].
- Extension: sign_ext=1 replicates the MSB of the extracted byte/half. Word loads ignore sign_ext.
- mem_write is 0 in all states except WRITE; mem_addr and mem_wd are don't-care outside READ/WRITE but must not cause writes.
- Error requests perform no memory access, and rdata is unchanged.
- Reset (async, any state):
  - state=IDLE; busy=0, done=0, err=0, mem_write=0, rdata=0, mem_addr=0, mem_wd=0.
  - Reset asserted during WRITE before the edge aborts the write, leaving memory unchanged.
  - No done pulse follows reset.
- start held high across DONE→IDLE is accepted again in IDLE, giving a new request every 2–4 cycles.

Test Plan:
- Word store/load: store 0xDEADBEEF @0x100 → mem_write high one cycle at mem_addr 0x100, done at +2. Load @0x100 → rdata 0xDEADBEEF, done at +2, err 0.
- Byte store RMW: word@0x200=0x11223344; sb 0xAB @0x202 → one READ then one write of 0x11AB3344, done at +3. lbu @0x202 → rdata 0x000000AB; lb @0x202 → 0xFFFFFFAB.
- Halfword: sh 0x8001 @0x206 over 0x00000000 → memory 0x80010000. lh @0x206 → 0xFFFF8001; lhu → 0x00008001.
- Errors: lw @0x101, sh @0x203, size=11 → done+err at +1, mem_write never asserted, rdata unchanged.
- Reset mid-op: sb @0x300 with reset asserted during WRITE → no write to 0x300 (prior value kept), all outputs 0. Next request completes normally.
- Busy/ignore: pulse start during READ of a load → ignored, only one done observed. Back-to-back start held high → second request accepted the cycle after done.
